// File: rtl/divisor_scheduler_if.sv
// Stream and divider handshake bundle for divisor_scheduler.
// slave is the scheduler's view; master is the surrounding environment's view.
interface divisor_scheduler_if #(
    parameter int SIZE = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_num;
    logic [SIZE-1:0] in_den;
    logic            div_start;
    logic [SIZE-1:0] div_num;
    logic [SIZE-1:0] div_den;
    logic            div_done;
    logic [SIZE-1:0] div_coc;
    logic [SIZE-1:0] div_res;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_coc;
    logic [SIZE-1:0] out_res;
    logic            out_dz;
    logic            out_err;

    modport slave (
        input  in_valid, in_num, in_den, div_done, div_coc, div_res, out_ready,
        output in_ready, div_start, div_num, div_den,
               out_valid, out_coc, out_res, out_dz, out_err
    );

    modport master (
        output in_valid, in_num, in_den, div_done, div_coc, div_res, out_ready,
        input  in_ready, div_start, div_num, div_den,
               out_valid, out_coc, out_res, out_dz, out_err
    );
endinterface

// File: rtl/divisor_scheduler.sv
// Request FIFO and sequencer in front of the divider: one division in flight,
// local divide-by-zero results, and a watchdog for a divider that never finishes.
module divisor_scheduler #(
    parameter int SIZE    = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    divisor_scheduler_if.slave bus
);
    // state | meaning
    // IDLE  | wait for a queued request and a free output register; dz resolved here
    // ISSUE | start pulse to the divider, watchdog armed
    // BUSY  | waiting for div_done or watchdog expiry
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT);

    logic [SIZE-1:0] num_mem_q [DEPTH];
    logic [SIZE-1:0] den_mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            full, empty, push, pop;

    state_t          state_q, state_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic [SIZE-1:0] div_num_q, div_num_d, div_den_q, div_den_d;
    logic            out_valid_q, out_valid_d;
    logic [SIZE-1:0] out_coc_q, out_coc_d, out_res_q, out_res_d;
    logic            out_dz_q, out_dz_d, out_err_q, out_err_d;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign push  = bus.in_valid && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                num_mem_q[i] <= '0;
                den_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                num_mem_q[wr_ptr_q] <= bus.in_num;
                den_mem_q[wr_ptr_q] <= bus.in_den;
                wr_ptr_q            <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            out_valid_q <= 1'b0;
            out_coc_q   <= '0;
            out_res_q   <= '0;
            out_dz_q    <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            div_num_q   <= div_num_d;
            div_den_q   <= div_den_d;
            out_valid_q <= out_valid_d;
            out_coc_q   <= out_coc_d;
            out_res_q   <= out_res_d;
            out_dz_q    <= out_dz_d;
            out_err_q   <= out_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        div_num_d   = div_num_q;
        div_den_d   = div_den_q;
        out_valid_d = out_valid_q;
        out_coc_d   = out_coc_q;
        out_res_d   = out_res_q;
        out_dz_d    = out_dz_q;
        out_err_d   = out_err_q;
        pop         = 1'b0;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty && (!out_valid_q || bus.out_ready)) begin
                    pop = 1'b1;
                    if (den_mem_q[rd_ptr_q] == '0) begin
                        out_valid_d = 1'b1;
                        out_coc_d   = '1;
                        out_res_d   = num_mem_q[rd_ptr_q];
                        out_dz_d    = 1'b1;
                        out_err_d   = 1'b0;
                    end else begin
                        div_num_d = num_mem_q[rd_ptr_q];
                        div_den_d = den_mem_q[rd_ptr_q];
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Watchdog counts down; expiry on the TIMEOUT-th BUSY cycle.
                wd_d    = WW'(TIMEOUT - 1);
                state_d = BUSY;
            end
            BUSY: begin
                if (bus.div_done) begin
                    out_valid_d = 1'b1;
                    out_coc_d   = bus.div_coc;
                    out_res_d   = bus.div_res;
                    out_dz_d    = 1'b0;
                    out_err_d   = 1'b0;
                    state_d     = IDLE;
                end else if (wd_q == '0) begin
                    out_valid_d = 1'b1;
                    out_coc_d   = '0;
                    out_res_d   = '0;
                    out_dz_d    = 1'b0;
                    out_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wd_d = wd_q - WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = !full;
    assign bus.div_start = (state_q == ISSUE);
    assign bus.div_num   = div_num_q;
    assign bus.div_den   = div_den_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_coc   = out_coc_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_dz    = out_dz_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_divisor_scheduler.sv
// Scoreboard bench for divisor_scheduler with a behavioural divider stub.
// Requests push their expected result; a monitor compares each presented result.
module tb_divisor_scheduler;
    localparam int SIZE    = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    divisor_scheduler_if #(.SIZE(SIZE)) bus_if ();

    divisor_scheduler #(.SIZE(SIZE), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [7:0] coc;
        logic [7:0] res;
        logic       dz;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Divider stub: answers num/den after a chosen latency, or hangs on request.
    bit         pend = 0;
    int         cnt_lat = 0;
    int         lat_fixed = 4;
    bit         rnd_lat = 0;
    int         hang_left = 0;
    int         hang_ref = 0;
    logic [7:0] lat_num, lat_den;
    int         last_start_cyc = 0;
    int         last_done_cyc = 0;
    int         n_starts = 0;
    bit         spur_req = 0;
    bit         prev_start = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend             = 0;
            prev_start       = 0;
            bus_if.div_done  = 1'b0;
        end else begin
            bus_if.div_done = 1'b0;
            if (spur_req) begin
                bus_if.div_done = 1'b1;
                bus_if.div_coc  = 8'hAA;
                bus_if.div_res  = 8'h55;
                spur_req        = 0;
            end
            if (pend) begin
                check("div_num_stable", bus_if.div_num, lat_num);
                check("div_den_stable", bus_if.div_den, lat_den);
                cnt_lat--;
                if (cnt_lat == 0) begin
                    bus_if.div_done = 1'b1;
                    bus_if.div_coc  = (lat_den != 0) ? lat_num / lat_den : 8'hFF;
                    bus_if.div_res  = (lat_den != 0) ? lat_num % lat_den : lat_num;
                    pend            = 0;
                    last_done_cyc   = cyc;
                end
            end
            if (bus_if.div_start) begin
                check("start_one_cycle", prev_start, 0);
                check("start_while_busy", pend, 0);
                check("start_den_nonzero", bus_if.div_den != 8'd0, 1);
                n_starts++;
                last_start_cyc = cyc;
                if (hang_left > 0) begin
                    hang_left--;
                end else begin
                    pend    = 1;
                    lat_num = bus_if.div_num;
                    lat_den = bus_if.div_den;
                    cnt_lat = rnd_lat ? int'($urandom_range(1, 10)) : lat_fixed;
                end
            end
            prev_start = bus_if.div_start;
        end
    end

    // Monitor: compares each newly presented result and checks holding while stalled.
    bit          prev_v = 0;
    bit          prev_acc = 0;
    logic [17:0] prev_out;
    logic [17:0] cur;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v   = 0;
            prev_acc = 0;
        end else begin
            cur = {bus_if.out_coc, bus_if.out_res, bus_if.out_dz, bus_if.out_err};
            if (prev_v && !prev_acc) begin
                check("out_hold_valid", bus_if.out_valid, 1);
                check("out_hold_data", cur, prev_out);
            end else if (bus_if.out_valid) begin
                check("result_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("result", cur, {e.coc, e.res, e.dz, e.err});
                    if (e.err)
                        check("timeout_latency", cyc - last_start_cyc, TIMEOUT + 1);
                    else if (!e.dz)
                        check("done_to_valid", cyc - last_done_cyc, 1);
                end
            end
            prev_v   = bus_if.out_valid;
            prev_acc = bus_if.out_valid && bus_if.out_ready;
            prev_out = cur;
        end
    end

    bit rnd_ready = 0;
    always @(posedge clk) begin
        #1;
        if (rnd_ready) bus_if.out_ready = ($urandom_range(0, 3) != 0);
    end

    int last_push_cyc = 0;

    // Called aligned 1 time unit after a rising edge; returns the same way.
    task automatic push_req(input logic [7:0] n, input logic [7:0] d);
        int   waited = 0;
        bit   ok = 0;
        bit   acc;
        exp_t x;
        bus_if.in_valid = 1'b1;
        bus_if.in_num   = n;
        bus_if.in_den   = d;
        while (!ok && waited < 300) begin
            @(negedge clk);
            acc = bus_if.in_ready;
            @(posedge clk);
            #1;
            if (acc) ok = 1;
            waited++;
        end
        bus_if.in_valid = 1'b0;
        if (ok) begin
            last_push_cyc = cyc;
            if (d == 0) begin
                x.coc = 8'hFF; x.res = n;    x.dz = 1'b1; x.err = 1'b0;
            end else if (hang_ref > 0) begin
                hang_ref--;
                x.coc = 8'h00; x.res = 8'h00; x.dz = 1'b0; x.err = 1'b1;
            end else begin
                x.coc = n / d; x.res = n % d; x.dz = 1'b0; x.err = 1'b0;
            end
            sb_q.push_back(x);
        end else begin
            check("push_accepted", 0, 1);
        end
    endtask

    task automatic drain(input int budget);
        int w = 0;
        while ((sb_q.size() != 0 || bus_if.out_valid) && w < budget) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", bus_if.in_ready, 1);
        check("rst_div_start", bus_if.div_start, 0);
        check("rst_div_num", bus_if.div_num, 0);
        check("rst_div_den", bus_if.div_den, 0);
        check("rst_out_valid", bus_if.out_valid, 0);
        check("rst_out_coc", bus_if.out_coc, 0);
        check("rst_out_res", bus_if.out_res, 0);
        check("rst_out_dz", bus_if.out_dz, 0);
        check("rst_out_err", bus_if.out_err, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    int  s0;
    int  rel_cyc;
    bit  any_v, any_s;

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_num    = '0;
        bus_if.in_den    = '0;
        bus_if.out_ready = 1'b0;
        bus_if.div_done  = 1'b0;
        bus_if.div_coc   = '0;
        bus_if.div_res   = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 100/7 with a free output
        bus_if.out_ready = 1'b1;
        lat_fixed = 5;
        push_req(8'd100, 8'd7);
        @(negedge clk);
        check("t1_start_low_pop", bus_if.div_start, 0);
        @(negedge clk);
        check("t1_start_high", bus_if.div_start, 1);
        check("t1_div_num", bus_if.div_num, 100);
        check("t1_div_den", bus_if.div_den, 7);
        @(negedge clk);
        check("t1_start_low_busy", bus_if.div_start, 0);
        @(posedge clk);
        #1;
        drain(50);
        check("t1_starts", n_starts, 1);

        // 55/0 resolved locally
        push_req(8'd55, 8'd0);
        @(negedge clk);
        check("t2_valid_before", bus_if.out_valid, 0);
        @(negedge clk);
        check("t2_valid_after", bus_if.out_valid, 1);
        check("t2_dz", bus_if.out_dz, 1);
        @(posedge clk);
        #1;
        drain(20);
        check("t2_no_start", n_starts, 1);

        // Downstream stall with a full FIFO
        bus_if.out_ready = 1'b0;
        lat_fixed = 3;
        push_req(8'd20, 8'd3);
        push_req(8'd9, 8'd0);
        push_req(8'd200, 8'd10);
        push_req(8'd7, 8'd7);
        push_req(8'd1, 8'd2);
        fork
            push_req(8'd8, 8'd4);
            begin
                repeat (15) @(negedge clk);
                check("t3_in_ready_full", bus_if.in_ready, 0);
                check("t3_out_stalled", bus_if.out_valid, 1);
                @(posedge clk);
                #1;
                rel_cyc = cyc;
                bus_if.out_ready = 1'b1;
            end
        join
        check("t3_sixth_after_release", last_push_cyc > rel_cyc, 1);
        drain(200);

        // Divider that never answers, followed by a normal request
        s0 = n_starts;
        hang_left = 1;
        hang_ref  = 1;
        push_req(8'd33, 8'd5);
        push_req(8'd40, 8'd6);
        drain(400);
        check("t4_starts", n_starts - s0, 2);

        // Reset while BUSY with requests queued
        lat_fixed = 40;
        push_req(8'd10, 8'd3);
        push_req(8'd11, 8'd3);
        push_req(8'd12, 8'd3);
        repeat (8) @(negedge clk);
        check("t5_busy_before_reset", pend, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        s0 = n_starts;
        any_v = 0;
        any_s = 0;
        repeat (12) begin
            @(negedge clk);
            any_v |= bus_if.out_valid;
            any_s |= bus_if.div_start;
        end
        check("t5_in_ready", bus_if.in_ready, 1);
        check("t5_no_valid", any_v, 0);
        check("t5_no_start", any_s | (n_starts != s0), 0);
        @(posedge clk);
        #1;

        // Spurious div_done while idle
        lat_fixed = 4;
        spur_req = 1;
        any_v = 0;
        any_s = 0;
        repeat (6) begin
            @(negedge clk);
            any_v |= bus_if.out_valid;
            any_s |= bus_if.div_start;
        end
        check("t6_no_valid", any_v, 0);
        check("t6_no_start", any_s, 0);
        @(posedge clk);
        #1;
        push_req(8'd90, 8'd9);
        drain(50);

        // Randomized traffic with random backpressure and divider latency
        rnd_ready = 1;
        rnd_lat   = 1;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] rn, rd;
            rn = 8'($urandom_range(0, 255));
            rd = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            push_req(rn, rd);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain(2000);
        rnd_ready = 0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
